// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, counter sizes and the responder state encoding.
package sram_pkg;
    localparam int SRAM_ADDR_W = 15;
    localparam int SRAM_DATA_W = 16;
    localparam int CNT_W = 16;
    localparam int LAT_W = 4;
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE} state_t;
endpackage

// File: rtl/sram_mem_array.sv
// sram_mem_array: single-port synchronous RAM, read-first, shaped for block-RAM inference.
module sram_mem_array
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: device-side async-SRAM model with programmable read latency,
// write commit on WE release, sticky protocol error and saturating access counters.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int DEPTH  = 2**ADDR_W,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    input  logic              sram_ce_n,
    input  logic              sram_oe_n,
    input  logic              sram_we_n,
    input  logic              err_clr,
    output logic              protocol_err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

    logic [ADDR_W-1:0] s_addr, a_reg;
    logic [DATA_W-1:0] s_data, w_data, rdata;
    logic              s_ce_n, s_oe_n, s_we_n;
    logic [LAT_W-1:0]  cnt;
    state_t            state;
    logic              rd, wr, addr_chg, rd_done, wr_done;

    assign rd       = !s_ce_n && s_we_n && !s_oe_n;
    assign wr       = !s_ce_n && !s_we_n;
    assign addr_chg = s_addr != a_reg;
    assign rd_done  = state == RD_DRIVE && (wr || !rd || addr_chg);
    assign wr_done  = state == WR_ACTIVE && !wr;
    assign sram_data = state == RD_DRIVE ? rdata : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_addr <= '0;
            s_data <= '0;
            s_ce_n <= 1'b1;
            s_oe_n <= 1'b1;
            s_we_n <= 1'b1;
        end else begin
            s_addr <= sram_addr;
            s_data <= sram_data;
            s_ce_n <= sram_ce_n;
            s_oe_n <= sram_oe_n;
            s_we_n <= sram_we_n;
        end
    end

    // The counter is reloaded on read entry or address change; the bus turns on when it would reach zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            w_data <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr) begin
                        state  <= WR_ACTIVE;
                        a_reg  <= s_addr;
                        w_data <= s_data;
                    end else if (rd) begin
                        state <= RD_WAIT;
                        a_reg <= s_addr;
                        cnt   <= LAT_LOAD;
                    end
                end
                RD_WAIT: begin
                    if (wr) begin
                        state  <= WR_ACTIVE;
                        a_reg  <= s_addr;
                        w_data <= s_data;
                    end else if (!rd) begin
                        state <= IDLE;
                    end else if (addr_chg) begin
                        a_reg <= s_addr;
                        cnt   <= LAT_LOAD;
                    end else if (cnt == LAT_W'(1)) begin
                        state <= RD_DRIVE;
                    end else begin
                        cnt <= cnt - LAT_W'(1);
                    end
                end
                RD_DRIVE: begin
                    if (wr) begin
                        state  <= WR_ACTIVE;
                        a_reg  <= s_addr;
                        w_data <= s_data;
                    end else if (!rd) begin
                        state <= IDLE;
                    end else if (addr_chg) begin
                        state <= RD_WAIT;
                        a_reg <= s_addr;
                        cnt   <= LAT_LOAD;
                    end
                end
                default: begin
                    if (!wr) state <= IDLE;
                    else w_data <= s_data;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            protocol_err <= 1'b0;
            rd_count     <= '0;
            wr_count     <= '0;
        end else begin
            protocol_err <= err_clr ? 1'b0 : (protocol_err || (state == WR_ACTIVE && wr && addr_chg));
            if (rd_done && rd_count != '1) rd_count <= rd_count + CNT_W'(1);
            if (wr_done && wr_count != '1) wr_count <= wr_count + CNT_W'(1);
        end
    end

    sram_mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .addr  (a_reg),
        .we    (wr_done),
        .wdata (w_data),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: randomized controller stimulus against a word-map model; a negedge monitor scores bus reads.
module tb_sram_responder;
    localparam int RD_LAT = 2;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 0, rst_n = 0, ce_n = 1, oe_n = 1, we_n = 1, err_clr = 0, tb_en = 0;
    logic [14:0] addr = '0;
    logic [15:0] tb_drv = '0;
    tri1  [15:0] bus;
    logic        protocol_err;
    logic [15:0] rd_count, wr_count;

    int          tests = 0, fails = 0, cyc = 0, drive_events = 0, exp_rd = 0, exp_wr = 0;
    exp_t        exp_q[$];
    logic [15:0] model [int];
    int          wlist[$];
    logic        was_drv = 0;
    logic [15:0] cur = '0;

    assign bus = tb_en ? tb_drv : 'z;

    sram_responder #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .sram_addr(addr), .sram_data(bus),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n), .err_clr(err_clr),
        .protocol_err(protocol_err), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Any undriven cycle reads as the pull-up value, so a DUT drive shows as a non-FFFF word.
    always @(negedge clk) begin
        logic drv;
        exp_t e;
        drv = !tb_en && bus != 16'hFFFF;
        if (drv && !was_drv) begin
            drive_events++;
            if (exp_q.size() == 0) begin
                check("unexpected_drive", bus, 16'hFFFF);
            end else begin
                e = exp_q.pop_front();
                cur = e.data;
                check("rd_data", bus, e.data);
                check("rd_latency", cyc, e.cyc);
            end
        end else if (drv) begin
            check("rd_hold", bus, cur);
        end
        was_drv = drv;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic idle_pins();
        ce_n = 1; oe_n = 1; we_n = 1; tb_en = 0;
    endtask

    task automatic do_write(input logic [14:0] a, input logic [15:0] d, input int len, input logic oe);
        addr = a; tb_drv = d; tb_en = 1; ce_n = 0; we_n = 0; oe_n = oe;
        tick(len);
        idle_pins();
        model[int'(a)] = d;
        wlist.push_back(int'(a));
        exp_wr++;
        tick(3);
    endtask

    task automatic do_read(input logic [14:0] a, input int hold);
        exp_t e;
        addr = a; ce_n = 0; we_n = 1; oe_n = 0;
        e.data = model[int'(a)];
        e.cyc = cyc + 1 + RD_LAT;
        exp_q.push_back(e);
        tick(hold);
        idle_pins();
        exp_rd++;
        tick(3);
    endtask

    initial begin
        exp_t e;
        int de, a;
        #1;
        check("reset_bus_z", bus, 16'hFFFF);
        check("reset_err", protocol_err, 0);
        check("reset_rd_count", rd_count, 0);
        check("reset_wr_count", wr_count, 0);
        tick(2);
        rst_n = 1;
        tick(2);

        do_write(15'h1234, 16'hABCD, 2, 1);
        do_read(15'h1234, 4);
        check("wr_count_first", wr_count, 1);
        check("rd_count_first", rd_count, 1);

        do_write(15'h0001, 16'h1111, 1, 1);
        do_write(15'h0002, 16'h2222, 3, 1);
        addr = 15'h0001; ce_n = 0; we_n = 1; oe_n = 0;
        e.data = 16'h1111; e.cyc = cyc + 1 + RD_LAT; exp_q.push_back(e);
        tick(4);
        addr = 15'h0002;
        e.data = 16'h2222; e.cyc = cyc + 1 + RD_LAT; exp_q.push_back(e);
        tick(4);
        idle_pins();
        exp_rd += 2;
        tick(3);
        check("rd_count_b2b", rd_count, exp_rd);

        do_write(15'h0003, 16'h5A5A, 2, 0);
        check("err_we_over_oe", protocol_err, 0);
        do_read(15'h0003, 3);

        do_write(15'h0011, 16'h1357, 1, 1);
        addr = 15'h0010; tb_drv = 16'hBEEF; tb_en = 1; ce_n = 0; we_n = 0; oe_n = 1;
        tick(2);
        addr = 15'h0011;
        tick(3);
        check("err_set", protocol_err, 1);
        err_clr = 1;
        tick(1);
        check("err_clr_priority", protocol_err, 0);
        err_clr = 0;
        tick(1);
        check("err_reflag", protocol_err, 1);
        idle_pins();
        model[16'h10] = 16'hBEEF;
        exp_wr++;
        tick(3);
        check("wr_count_err", wr_count, exp_wr);
        do_read(15'h0010, 4);
        do_read(15'h0011, 4);
        err_clr = 1;
        tick(1);
        err_clr = 0;
        check("err_cleared", protocol_err, 0);

        de = drive_events;
        addr = 15'h0002; ce_n = 0; we_n = 1; oe_n = 0;
        tick(1);
        idle_pins();
        tick(4);
        check("abort_no_drive", drive_events, de);
        check("abort_rd_count", rd_count, exp_rd);

        repeat (30) begin
            if (wlist.size() == 0 || $urandom_range(0, 1) == 0)
                do_write(15'h0100 + 15'($urandom_range(0, 15)), 16'($urandom_range(0, 16'hFFFE)),
                         $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            else begin
                a = wlist[$urandom_range(0, wlist.size() - 1)];
                do_read(15'(a), $urandom_range(RD_LAT + 1, RD_LAT + 4));
            end
        end
        check("rand_rd_count", rd_count, exp_rd);
        check("rand_wr_count", wr_count, exp_wr);

        addr = 15'h1234; ce_n = 0; we_n = 1; oe_n = 0;
        e.data = model[16'h1234]; e.cyc = cyc + 1 + RD_LAT; exp_q.push_back(e);
        tick(RD_LAT + 2);
        rst_n = 0;
        #1;
        check("reset_mid_read_z", bus, 16'hFFFF);
        check("reset_mid_read_rd", rd_count, 0);
        check("reset_mid_read_wr", wr_count, 0);
        exp_rd = 0; exp_wr = 0;
        idle_pins();
        tick(2);
        rst_n = 1;
        tick(2);

        addr = 15'h0002; tb_drv = 16'h7777; tb_en = 1; ce_n = 0; we_n = 0; oe_n = 1;
        tick(3);
        rst_n = 0;
        idle_pins();
        tick(2);
        rst_n = 1;
        tick(2);
        do_read(15'h0002, 4);
        check("reset_mid_write_wr", wr_count, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
        check("scoreboard_empty", exp_q.size(), 0);
        check("final_rd_count", rd_count, exp_rd);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
